// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-lane round-robin mux arbiter.
//   N_LANES  number of requesters sharing the datapath mux
//   SEL_W    width of a lane index / mux select
//   state_e  arbiter FSM states (IDLE, GRANT)
//   onehot() lane index -> one-hot grant vector
package mux_arb_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_LANES-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational rotate-priority picker.
//   req   in   8  request vector
//   ptr   in   3  highest-priority lane; search order ptr, ptr+1, ... wrapping
//   mask  in   8  lanes to exclude from this search
//   found out  1  some unmasked lane is requesting
//   idx   out  3  first unmasked requesting lane in search order (ptr when !found)
module rr_pick_8
  import mux_arb_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [N_LANES-1:0] mask,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [N_LANES-1:0] cand;
  logic [SEL_W-1:0]   lane;

  assign cand = req & ~mask;

  // Walk the rotation from the far end back towards ptr so the lane closest
  // to ptr is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    lane  = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      lane = ptr + SEL_W'(k);
      if (cand[lane]) begin
        found = 1'b1;
        idx   = lane;
      end
    end
  end

endmodule

// File: rtl/mux_8_1_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 8:1 WIDTH-bit mux.
// Picks a winner among 8 level requesters, holds the grant for at most
// MAX_HOLD cycles while others wait (0 = unlimited), and registers the
// selected lane's data towards the consumer.
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high
//   req      in   per-lane request level
//   d        in   lane data, lane i at d[i*WIDTH +: WIDTH]
//   gnt      out  one-hot grant (registered)
//   sel      out  granted lane index (registered mux select)
//   busy     out  a grant is active
//   y        out  registered d[sel], one cycle behind gnt
//   y_valid  out  y carries granted-lane data this cycle
module mux_8_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_LANES-1:0]         req,
  input  logic [N_LANES*WIDTH-1:0]   d,
  output logic [N_LANES-1:0]         gnt,
  output logic [SEL_W-1:0]           sel,
  output logic                       busy,
  output logic [WIDTH-1:0]           y,
  output logic                       y_valid
);

  localparam int              HC_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

  logic [N_LANES-1:0][WIDTH-1:0] d_lane;
  state_e                        state;
  logic [SEL_W-1:0]              ptr;
  logic [HC_W-1:0]               hold_cnt;

  logic                          cur_req;
  logic                          expired;
  logic                          release_g;
  logic [SEL_W-1:0]              pick_ptr;
  logic [N_LANES-1:0]            pick_mask;
  logic                          pick_found;
  logic [SEL_W-1:0]              pick_idx;

  assign d_lane = d;

  // A drop takes precedence over expiry: both release, but only a dropped
  // lane is masked, so an expired lane that still requests can win again
  // at the end of the rotation.
  assign cur_req   = req[sel];
  assign expired   = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);
  assign release_g = (state == GRANT) && (!cur_req || expired);

  // While granting, the next search starts just past the current owner so
  // handover needs no idle cycle.
  always_comb begin
    pick_ptr  = ptr;
    pick_mask = '0;
    if (state == GRANT) begin
      pick_ptr = sel + SEL_W'(1);
      if (!cur_req) pick_mask = onehot(sel);
    end
  end

  rr_pick_8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      // Output stage follows the grant registers by one cycle; y only
      // moves while a grant is active so it holds when y_valid drops.
      y_valid <= busy;
      if (busy) y <= d_lane[sel];

      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt      <= onehot(pick_idx);
            sel      <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= HC_W'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!release_g) begin
            if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HC_W'(1);
          end else begin
            ptr <= sel + SEL_W'(1);
            if (pick_found) begin
              gnt      <= onehot(pick_idx);
              sel      <= pick_idx;
              hold_cnt <= HC_W'(1);
            end else begin
              gnt      <= '0;
              busy     <= 1'b0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_8_1_rr_arbiter.sv
module tb_mux_8_1_rr_arbiter;

  localparam int W  = 3;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     req;
  logic [8*W-1:0] d;
  logic [7:0]     gnt;
  logic [2:0]     sel;
  logic           busy;
  logic [W-1:0]   y;
  logic           y_valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_8_1_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .d       (d),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .y       (y),
    .y_valid (y_valid)
  );

  // Reference model: who owns the bus, for how many cycles, and where the
  // rotation starts next. Owner -1 means nobody.
  int           m_own = -1;
  int           m_cnt = 0;
  int           m_ptr = 0;
  logic [2:0]   m_sel = '0;
  logic [W-1:0] m_y   = '0;
  logic         m_yv  = 1'b0;

  function automatic int search(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++)
      if (r[(from + k) % 8]) return (from + k) % 8;
    return -1;
  endfunction

  always @(posedge clk) begin : model_blk
    int w;
    if (reset) begin
      m_own <= -1; m_cnt <= 0; m_ptr <= 0; m_sel <= '0; m_y <= '0; m_yv <= 1'b0;
    end else begin
      m_yv <= (m_own >= 0);
      if (m_own >= 0) m_y <= d[m_own*W +: W];
      if (m_own < 0) begin
        w = search(req, m_ptr);
        if (w >= 0) begin m_own <= w; m_cnt <= 1; m_sel <= 3'(w); end
      end else if (req[m_own] && m_cnt < MH) begin
        m_cnt <= m_cnt + 1;
      end else begin
        m_ptr <= (m_own + 1) % 8;
        w = search(req, (m_own + 1) % 8);
        if (w >= 0) begin m_own <= w; m_cnt <= 1; m_sel <= 3'(w); end
        else m_own <= -1;
      end
    end
  end

  function automatic logic [15:0] obs();
    return {gnt, sel, busy, y, y_valid};
  endfunction

  function automatic logic [15:0] expv();
    logic [7:0] g;
    g = (m_own >= 0) ? (8'd1 << m_own) : 8'd0;
    return {g, m_sel, (m_own >= 0), m_y, m_yv};
  endfunction

  task automatic test_reset();
    reset = 1'b1; req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== 16'h0) $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs(), 16'h0);
      else n_pass++;
    end
    reset = 1'b0; req = 8'h00;
    @(negedge clk);
    n_chk++;
    if (obs() !== 16'h0) $display("FAIL reset_idle got=%h want=%h", obs(), 16'h0);
    else n_pass++;
  endtask

  task automatic test_single_lane();
    req = 8'h20;
    @(negedge clk);
    n_chk++;
    if ({gnt, sel, busy, y_valid} !== {8'h20, 3'd5, 1'b1, 1'b0})
      $display("FAIL lane5_first got=%h/%0d/%b/%b want=20/5/1/0", gnt, sel, busy, y_valid);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if ({gnt, sel, y, y_valid} !== {8'h20, 3'd5, 3'b101, 1'b1})
        $display("FAIL lane5_hold[%0d] got=%h/%0d/%b/%b want=20/5/101/1", i, gnt, sel, y, y_valid);
      else n_pass++;
    end
    req = 8'h00;
    @(negedge clk);
    n_chk++;
    if ({gnt, busy, y, y_valid} !== {8'h00, 1'b0, 3'b101, 1'b1})
      $display("FAIL lane5_release got=%h/%b/%b/%b want=00/0/101/1", gnt, busy, y, y_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({busy, y, y_valid} !== {1'b0, 3'b101, 1'b0})
      $display("FAIL y_hold got=%b/%b/%b want=0/101/0", busy, y, y_valid);
    else n_pass++;
    // ptr is now 6: a lone lane 0 is reached by wrapping past 7
    req = 8'h01;
    @(negedge clk);
    n_chk++;
    if ({gnt, sel, busy} !== {8'h01, 3'd0, 1'b1})
      $display("FAIL wrap_lane0 got=%h/%0d/%b want=01/0/1", gnt, sel, busy);
    else n_pass++;
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_req();
    logic [7:0] eg;
    reset = 1'b1; req = 8'h00;
    @(negedge clk);
    reset = 1'b0; req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      eg = 8'd1 << ((k / 4) % 8);
      n_chk++;
      if (gnt !== eg || busy !== 1'b1)
        $display("FAIL all_req[%0d] got gnt=%h busy=%b want gnt=%h busy=1", k, gnt, busy, eg);
      else n_pass++;
      n_chk++;
      if (obs() !== expv()) $display("FAIL all_req_model[%0d] got=%h want=%h", k, obs(), expv());
      else n_pass++;
    end
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ptr_order();
    logic [7:0] eg;
    req = 8'h08;
    @(negedge clk);
    n_chk++;
    if (gnt !== 8'h08) $display("FAIL lane3_setup got=%h want=08", gnt);
    else n_pass++;
    req = 8'h00;
    @(negedge clk);
    req = 8'h48;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      eg = (k < 4) ? 8'h40 : 8'h08;
      n_chk++;
      if (gnt !== eg) $display("FAIL ptr4_order[%0d] got=%h want=%h", k, gnt, eg);
      else n_pass++;
    end
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_wrap();
    req = 8'h04;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_chk++;
      if ({gnt, sel, busy} !== {8'h04, 3'd2, 1'b1} || (k > 0 && y_valid !== 1'b1))
        $display("FAIL lone_hold[%0d] got=%h/%0d/%b/%b want=04/2/1/1", k, gnt, sel, busy, y_valid);
      else n_pass++;
    end
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; req = 8'h00;
    @(negedge clk);
    reset = 1'b0; req = 8'h0A;
    @(negedge clk);
    n_chk++;
    if ({gnt, sel, busy} !== {8'h02, 3'd1, 1'b1})
      $display("FAIL mid_pre got=%h/%0d/%b want=02/1/1", gnt, sel, busy);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (obs() !== 16'h0) $display("FAIL mid_reset got=%h want=%h", obs(), 16'h0);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (obs() !== {8'h02, 3'd1, 1'b1, 3'd0, 1'b0})
      $display("FAIL mid_regrant got=%h want=%h", obs(), {8'h02, 3'd1, 1'b1, 3'd0, 1'b0});
    else n_pass++;
    req = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] r;
    r = 8'h00;
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < 8; l++)
        if ($urandom_range(0, 5) == 0) r[l] = ~r[l];
      req   = r;
      reset = ($urandom_range(0, 59) == 0);
      d     = 24'($urandom);
      @(negedge clk);
      n_chk++;
      if (obs() !== expv()) $display("FAIL random[%0d] got=%h want=%h", c, obs(), expv());
      else n_pass++;
    end
    reset = 1'b0; req = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    for (int i = 0; i < 8; i++) d[i*W +: W] = W'(i);
    test_reset();
    test_single_lane();
    test_all_req();
    test_ptr_order();
    test_hold_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
